regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp_if.sv | 30 +++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// allocation request and the registered busy vector.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, optional write bypass,
// optional hardwired zero register and per-register busy (scoreboard) bits.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic         clk,
  input logic         reset_n,
  regfile_mp_if.slave bus
);
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

  // Address names real, writable storage: in range and not the zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < LIMIT) && !(ZERO_REG && (a == '0));
  endfunction

  logic [XLEN-1:0]     regs   [NREGS];
  logic [XLEN-1:0]     wr_val [NREGS];
  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    wr_hit;
  logic [NREGS-1:0]    alloc_hit;
  logic [NRD*XLEN-1:0] rd_data_c;
  logic [NRD-1:0]      rd_busy_c;

  // Ports are scanned in ascending order so the highest-index port wins.
  always_comb begin
    logic [AW-1:0] wa;
    wa        = '0;
    wr_hit    = '0;
    alloc_hit = '0;
    for (int unsigned r = 0; r < NREGS; r++) wr_val[r] = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      wa = bus.wr_addr[j*AW +: AW];
      if (bus.wr_en[j] && addr_ok(wa)) begin
        wr_hit[wa] = 1'b1;
        wr_val[wa] = bus.wr_data[j*XLEN +: XLEN];
      end
    end
    if (bus.alloc_en && addr_ok(bus.alloc_addr)) alloc_hit[bus.alloc_addr] = 1'b1;
  end

  // A same-edge alloc overrides the clear from a completing write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
      end
      busy <= alloc_hit | (busy & ~wr_hit);
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra        = '0;
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (addr_ok(ra)) begin
        rd_data_c[i*XLEN +: XLEN] = regs[ra];
        rd_busy_c[i]              = busy[ra];
        if (BYPASS) begin
          for (int unsigned j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra)) begin
              rd_data_c[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
              rd_busy_c[i]              = 1'b0;
            end
          end
        end
      end
    end
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing 32-entry instance and a non-bypassing
// 24-entry instance share stimulus and are checked against an array model.
module tb_regfile_mp;
  logic clk;
  logic reset_n;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus0 ();
  regfile_mp_if #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(2)) bus1 ();

  assign bus1.rd_addr    = bus0.rd_addr;
  assign bus1.wr_en      = bus0.wr_en;
  assign bus1.wr_addr    = bus0.wr_addr;
  assign bus1.wr_data    = bus0.wr_data;
  assign bus1.alloc_en   = bus0.alloc_en;
  assign bus1.alloc_addr = bus0.alloc_addr;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  regfile_mp #(.XLEN(32), .NREGS(24), .NRD(2), .NWR(2), .ZERO_REG(1'b1), .BYPASS(1'b0))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [2][32];
  logic        m_busy [2][32];

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ae;
    logic [4:0]  aa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic        ebv3;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int nregs_of(input int k);
    return (k == 1) ? 24 : 32;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin
        m_regs[k][r] = '0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  function automatic logic [31:0] mread(input int k, input logic [4:0] a, output logic b);
    logic [31:0] d;
    logic        hit;
    d   = '0;
    b   = 1'b0;
    hit = 1'b0;
    if (a != 5'd0 && int'(a) < nregs_of(k)) begin
      d = m_regs[k][a];
      if (k == 0) begin
        for (int j = 0; j < 2; j++)
          if (bus0.wr_en[j] && bus0.wr_addr[j*5 +: 5] == a) begin
            d   = bus0.wr_data[j*32 +: 32];
            hit = 1'b1;
          end
      end
      b = m_busy[k][a] & !hit;
    end
    return d;
  endfunction

  task automatic model_update();
    logic w [32];
    logic [4:0] a;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) w[r] = 1'b0;
      for (int j = 0; j < 2; j++) begin
        a = bus0.wr_addr[j*5 +: 5];
        if (bus0.wr_en[j] && a != 5'd0 && int'(a) < nregs_of(k)) begin
          m_regs[k][a] = bus0.wr_data[j*32 +: 32];
          w[a] = 1'b1;
        end
      end
      for (int r = 0; r < 32; r++) if (w[r]) m_busy[k][r] = 1'b0;
      a = bus0.alloc_addr;
      if (bus0.alloc_en && a != 5'd0 && int'(a) < nregs_of(k)) m_busy[k][a] = 1'b1;
    end
  endtask

  task automatic check_model();
    logic [31:0] ed, ad, ebv, abv;
    logic        eb, ab;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) begin
        ed = mread(k, bus0.rd_addr[i*5 +: 5], eb);
        ad = (k == 0) ? bus0.rd_data[i*32 +: 32] : bus1.rd_data[i*32 +: 32];
        ab = (k == 0) ? bus0.rd_busy[i] : bus1.rd_busy[i];
        chk($sformatf("dut%0d rd_data%0d addr %0d", k, i, bus0.rd_addr[i*5 +: 5]), 64'(ad), 64'(ed));
        chk($sformatf("dut%0d rd_busy%0d addr %0d", k, i, bus0.rd_addr[i*5 +: 5]), 64'(ab), 64'(eb));
      end
      ebv = '0;
      for (int r = 0; r < nregs_of(k); r++) ebv[r] = m_busy[k][r];
      abv = (k == 0) ? bus0.busy_vec : 32'(bus1.busy_vec);
      chk($sformatf("dut%0d busy_vec", k), 64'(abv), 64'(ebv));
    end
  endtask

  task automatic tick();
    #2;
    check_model();
    @(posedge clk);
    if (reset_n) model_update();
    #1;
  endtask

  task automatic set_idle();
    bus0.wr_en      = '0;
    bus0.wr_addr    = '0;
    bus0.wr_data    = '0;
    bus0.alloc_en   = 1'b0;
    bus0.alloc_addr = '0;
  endtask

  task automatic set_vec(input vec_t v);
    bus0.wr_en      = v.we;
    bus0.wr_addr    = {v.wa1, v.wa0};
    bus0.wr_data    = {v.wd1, v.wd0};
    bus0.alloc_en   = v.ae;
    bus0.alloc_addr = v.aa;
    bus0.rd_addr    = {v.ra1, v.ra0};
  endtask

  initial begin
    //           we     wa0    wd0            wa1    wd1            ae    aa     ra0    ra1    e0             e1             eb     ebv3
    tbl[0]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0};
    tbl[2]  = '{2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 1'b0, 5'd0, 5'd7, 5'd5, 32'h22222222, 32'hDEADBEEF, 2'b00, 1'b0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h22222222, 32'h22222222, 2'b00, 1'b0};
    tbl[4]  = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0};
    tbl[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0};
    tbl[6]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h0,        32'h0,        2'b11, 1'b1};
    tbl[7]  = '{2'b10, 5'd0, 32'h0,        5'd3, 32'h5,        1'b0, 5'd0, 5'd3, 5'd0, 32'h5,        32'h0,        2'b00, 1'b1};
    tbl[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h5,        32'h5,        2'b00, 1'b0};
    tbl[9]  = '{2'b01, 5'd3, 32'h77,       5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 32'h77,       32'h0,        2'b00, 1'b0};
    tbl[10] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h77,       32'h77,       2'b11, 1'b1};

    reset_n = 1'b0;
    set_idle();
    bus0.rd_addr = '0;
    model_clear();
    #2;
    for (int a = 0; a < 32; a++) begin
      bus0.rd_addr = {5'(a), 5'(a)};
      #1;
      chk($sformatf("reset rd_data addr %0d", a), 64'(bus0.rd_data), 64'd0);
      chk($sformatf("reset rd_busy addr %0d", a), 64'(bus0.rd_busy), 64'd0);
    end
    chk("reset busy_vec dut0", 64'(bus0.busy_vec), 64'd0);
    chk("reset busy_vec dut1", 64'(bus1.busy_vec), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 11; n++) begin
      set_vec(tbl[n]);
      #1;
      chk($sformatf("vec%0d rd_data0", n), 64'(bus0.rd_data[31:0]), 64'(tbl[n].e0));
      chk($sformatf("vec%0d rd_data1", n), 64'(bus0.rd_data[63:32]), 64'(tbl[n].e1));
      chk($sformatf("vec%0d rd_busy", n), 64'(bus0.rd_busy), 64'(tbl[n].eb));
      chk($sformatf("vec%0d busy_vec3", n), 64'(bus0.busy_vec[3]), 64'(tbl[n].ebv3));
      tick();
    end

    // Asynchronous reset clears storage and busy bits without a clock edge.
    set_idle();
    bus0.wr_en      = 2'b01;
    bus0.wr_addr    = {5'd0, 5'd9};
    bus0.wr_data    = {32'h0, 32'hA5};
    bus0.alloc_en   = 1'b1;
    bus0.alloc_addr = 5'd9;
    tick();
    set_idle();
    bus0.rd_addr = {5'd9, 5'd9};
    #1;
    chk("pre-reset x9 data", 64'(bus0.rd_data[31:0]), 64'h0A5);
    chk("pre-reset busy_vec9", 64'(bus0.busy_vec[9]), 64'd1);
    chk("pre-reset rd_busy x9", 64'(bus0.rd_busy), 64'b11);
    #1;
    reset_n = 1'b0;
    #1;
    model_clear();
    chk("async reset busy_vec dut0", 64'(bus0.busy_vec), 64'd0);
    chk("async reset busy_vec dut1", 64'(bus1.busy_vec), 64'd0);
    chk("async reset x9 dut0", 64'(bus0.rd_data), 64'd0);
    chk("async reset x9 dut1", 64'(bus1.rd_data), 64'd0);
    bus0.wr_en      = 2'b11;
    bus0.wr_addr    = {5'd9, 5'd4};
    bus0.wr_data    = {32'h1234, 32'h5678};
    bus0.alloc_en   = 1'b1;
    bus0.alloc_addr = 5'd4;
    @(posedge clk);
    #1;
    set_idle();
    bus0.rd_addr = {5'd9, 5'd4};
    #1;
    chk("in-reset write ignored dut0", 64'(bus0.rd_data), 64'd0);
    chk("in-reset write ignored dut1", 64'(bus1.rd_data), 64'd0);
    chk("in-reset alloc ignored", 64'(bus0.busy_vec), 64'd0);
    reset_n = 1'b1;
    #1;
    tick();

    for (int n = 0; n < 400; n++) begin
      bus0.wr_en      = 2'($urandom_range(0, 3));
      bus0.wr_addr    = 10'($urandom);
      bus0.wr_data    = {$urandom, $urandom};
      bus0.alloc_en   = 1'($urandom_range(0, 1));
      bus0.alloc_addr = 5'($urandom);
      bus0.rd_addr    = 10'($urandom);
      if ($urandom_range(0, 3) == 0) bus0.rd_addr[4:0] = bus0.wr_addr[9:5];
      if ($urandom_range(0, 3) == 0) bus0.wr_addr[9:5] = bus0.wr_addr[4:0];
      if ($urandom_range(0, 3) == 0) bus0.alloc_addr = bus0.wr_addr[4:0];
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
